// File: rtl/rs_tag_allocator_pkg.sv
// Shared RS tag definitions, common to the tag allocator, map table and reservation stations.
// Tag 0 is the null tag and is never issued.
package rs_tag_allocator_pkg;

  localparam int RSTAG_W = 8;
  localparam logic [RSTAG_W-1:0] RSTAG_NULL = 8'd0;
  localparam int NUM_TAGS_DEFAULT = 16;

endpackage

// File: rtl/rs_tag_allocator_free_fifo.sv
// Circular free list of RS tags: two combinational read ports at head, two write ports at tail.
// Reset and flush both refill the list with tags 1..NUM_TAGS in order.
module tag_free_fifo
  import rs_tag_allocator_pkg::*;
#(
  parameter int NUM_TAGS = NUM_TAGS_DEFAULT,
  parameter int PTR_W    = $clog2(NUM_TAGS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic [1:0]         pop_num,
  input  logic               push1_valid,
  input  logic [RSTAG_W-1:0] push1_tag,
  input  logic               push2_valid,
  input  logic [RSTAG_W-1:0] push2_tag,
  output logic [RSTAG_W-1:0] head_tag,
  output logic [RSTAG_W-1:0] next_tag,
  output logic [PTR_W:0]     count
);

  localparam logic [PTR_W+1:0] NUM_EXT = (PTR_W+2)'(NUM_TAGS);
  localparam logic [PTR_W:0]   NUM_CNT = (PTR_W+1)'(NUM_TAGS);

  logic [RSTAG_W-1:0] entries [NUM_TAGS];
  logic [PTR_W-1:0]   head_reg, tail_reg;
  logic [PTR_W:0]     count_reg;
  logic [PTR_W-1:0]   head_plus1, tail_plus1;
  logic               wr0_valid, wr1_valid;
  logic [RSTAG_W-1:0] wr0_tag, wr1_tag;
  logic [1:0]         push_num;

  // Pointers wrap modulo NUM_TAGS, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] inc);
    logic [PTR_W+1:0] s;
    s = {2'b00, p} + {{PTR_W{1'b0}}, inc};
    if (s >= NUM_EXT) s = s - NUM_EXT;
    return PTR_W'(s);
  endfunction

  assign head_plus1 = ptr_add(head_reg, 2'd1);
  assign tail_plus1 = ptr_add(tail_reg, 2'd1);

  // Compact the two write ports so a lone free2 still lands at tail.
  assign wr0_valid = push1_valid || push2_valid;
  assign wr0_tag   = push1_valid ? push1_tag : push2_tag;
  assign wr1_valid = push1_valid && push2_valid;
  assign wr1_tag   = push2_tag;
  assign push_num  = {1'b0, push1_valid} + {1'b0, push2_valid};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TAGS; gi++) begin : g_entry
      logic [RSTAG_W-1:0] tag_reg;
      always_ff @(posedge clock) begin
        if (reset || flush)
          tag_reg <= RSTAG_W'(gi + 1);
        else if (wr0_valid && tail_reg == PTR_W'(gi))
          tag_reg <= wr0_tag;
        else if (wr1_valid && tail_plus1 == PTR_W'(gi))
          tag_reg <= wr1_tag;
      end
      assign entries[gi] = tag_reg;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= NUM_CNT;
    end else begin
      head_reg  <= ptr_add(head_reg, pop_num);
      tail_reg  <= ptr_add(tail_reg, push_num);
      count_reg <= count_reg + {{(PTR_W-1){1'b0}}, push_num} - {{(PTR_W-1){1'b0}}, pop_num};
    end
  end

  assign head_tag = entries[head_reg];
  assign next_tag = entries[head_plus1];
  assign count    = count_reg;

endmodule

// File: rtl/rs_tag_allocator.sv
// Dual-port RS tag allocator: in-order grants of up to two tags per cycle from a free list,
// up to two tag returns per cycle, flush recovery and a sticky protocol-error flag.
module rs_tag_allocator
  import rs_tag_allocator_pkg::*;
#(
  parameter int NUM_TAGS = NUM_TAGS_DEFAULT,
  parameter int PTR_W    = $clog2(NUM_TAGS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               req1,
  input  logic               req2,
  output logic               grant1,
  output logic               grant2,
  output logic [RSTAG_W-1:0] tag1_out,
  output logic [RSTAG_W-1:0] tag2_out,
  input  logic               free1_valid,
  input  logic [RSTAG_W-1:0] free1_tag,
  input  logic               free2_valid,
  input  logic [RSTAG_W-1:0] free2_tag,
  output logic [PTR_W:0]     free_count,
  output logic               empty,
  output logic               error
);

  localparam logic [PTR_W+1:0]   NUM_EXT = (PTR_W+2)'(NUM_TAGS);
  localparam logic [RSTAG_W-1:0] MAX_TAG = RSTAG_W'(NUM_TAGS);

  logic [PTR_W:0]     count;
  logic [RSTAG_W-1:0] head_tag, next_tag;
  logic [1:0]         grant_num;
  logic [PTR_W+1:0]   room, room_after1;
  logic               f1_tag_ok, f2_tag_ok, f2_dup;
  logic               f1_accept, f2_accept, error_event;
  logic               error_reg;

  assign grant1    = !reset && req1 && (count != '0);
  assign grant2    = !reset && req1 && req2 && (count >= (PTR_W+1)'(2));
  assign tag1_out  = grant1 ? head_tag : RSTAG_NULL;
  assign tag2_out  = grant2 ? next_tag : RSTAG_NULL;
  assign grant_num = {1'b0, grant1} + {1'b0, grant2};

  // Room left after this cycle's allocations; frees beyond it would overfill the pool.
  assign room        = NUM_EXT - {1'b0, count} + {{PTR_W{1'b0}}, grant_num};
  assign room_after1 = room - {{(PTR_W+1){1'b0}}, f1_accept};

  assign f1_tag_ok = (free1_tag != RSTAG_NULL) && (free1_tag <= MAX_TAG);
  assign f2_tag_ok = (free2_tag != RSTAG_NULL) && (free2_tag <= MAX_TAG);
  assign f2_dup    = free1_valid && free2_valid && (free1_tag == free2_tag);

  assign f1_accept = free1_valid && f1_tag_ok && (room != '0);
  assign f2_accept = free2_valid && f2_tag_ok && !f2_dup && (room_after1 != '0);

  assign error_event = (free1_valid && !f1_accept) || (free2_valid && !f2_accept);

  tag_free_fifo #(
    .NUM_TAGS (NUM_TAGS),
    .PTR_W    (PTR_W)
  ) u_free_fifo (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .pop_num     (grant_num),
    .push1_valid (f1_accept),
    .push1_tag   (free1_tag),
    .push2_valid (f2_accept),
    .push2_tag   (free2_tag),
    .head_tag    (head_tag),
    .next_tag    (next_tag),
    .count       (count)
  );

  // Flush discards frees, so it neither raises nor clears the error flag.
  always_ff @(posedge clock) begin
    if (reset)
      error_reg <= 1'b0;
    else if (!flush && error_event)
      error_reg <= 1'b1;
  end

  assign free_count = count;
  assign empty      = (count == '0);
  assign error      = error_reg;

endmodule
